// File: rtl/md5_pkg.sv
// Shared types, constants and elaboration-time helpers for the MD5 block builder.
package md5_pkg;

    localparam int BLOCK_WIDTH    = 512;
    localparam int BLOCK_BYTES    = BLOCK_WIDTH / 8;
    localparam int LEN_OFFSET     = 56;
    localparam int MAX_MSG_BYTES  = LEN_OFFSET - 1;
    localparam int BCD_MAX_DIGITS = 16;

    typedef logic [7:0]             byte_t;
    typedef logic [BLOCK_WIDTH-1:0] md5_block_t;

    localparam byte_t PAD_BYTE   = 8'h80;
    localparam byte_t ASCII_ZERO = 8'h30;

    typedef enum logic [1:0] {
        LOAD,
        FILL,
        OFFER,
        DONE
    } state_t;

    // Packed BCD, digit 0 (least significant) in the low nibble.
    function automatic logic [4*BCD_MAX_DIGITS-1:0] to_bcd(input int value);
        logic [4*BCD_MAX_DIGITS-1:0] bcd;
        int v;
        bcd = '0;
        v   = value;
        for (int d = 0; d < BCD_MAX_DIGITS; d++) begin
            bcd[4*d +: 4] = 4'(v % 10);
            v             = v / 10;
        end
        return bcd;
    endfunction

    function automatic int bcd_len(input int value);
        int n;
        int v;
        n = 1;
        v = value / 10;
        for (int d = 1; d < BCD_MAX_DIGITS; d++) begin
            if (v != 0) begin
                n = n + 1;
                v = v / 10;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Decimal nonce counter: ripple-carry BCD digits plus the count of active digits.
module bcd_counter
    import md5_pkg::*;
#(
    parameter int DIGITS      = 10,
    parameter int START_VALUE = 1,
    localparam int NW         = $clog2(DIGITS + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                inc,
    output logic [4*DIGITS-1:0] digits,
    output logic [NW-1:0]       num_digits,
    output logic                grow,
    output logic                overflow
);

    localparam logic [4*BCD_MAX_DIGITS-1:0] START_BCD_ALL = to_bcd(START_VALUE);
    localparam logic [4*DIGITS-1:0]         START_BCD     = START_BCD_ALL[4*DIGITS-1:0];
    localparam logic [NW-1:0]               START_LEN     = NW'(bcd_len(START_VALUE));

    logic [4*DIGITS-1:0] digits_q, digits_d;
    logic [NW-1:0]       num_q, num_d;
    logic [DIGITS-1:0]   digit_nine;
    logic                carry;

    // Inactive digits count as nines so the reduction flags "all active digits are 9".
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nine
            assign digit_nine[gi] = (digits_q[4*gi +: 4] == 4'd9) || (NW'(gi) >= num_q);
        end
    endgenerate

    assign grow     = &digit_nine;
    assign overflow = grow && (num_q == NW'(DIGITS));

    always_comb begin
        digits_d = digits_q;
        num_d    = num_q;
        carry    = 1'b0;
        if (inc && !overflow) begin
            carry = 1'b1;
            for (int d = 0; d < DIGITS; d++) begin
                if (carry) begin
                    if (digits_q[4*d +: 4] == 4'd9) begin
                        digits_d[4*d +: 4] = 4'd0;
                    end else begin
                        digits_d[4*d +: 4] = digits_q[4*d +: 4] + 4'd1;
                        carry              = 1'b0;
                    end
                end
            end
            if (grow) begin
                num_d = num_q + NW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digits_q <= START_BCD;
            num_q    <= START_LEN;
        end else begin
            digits_q <= digits_d;
            num_q    <= num_d;
        end
    end

    assign digits     = digits_q;
    assign num_digits = num_q;

endmodule

// File: rtl/md5_block_builder.sv
// Builds padded single-block MD5 messages of key||decimal nonce, one byte per cycle,
// and offers each finished block on a ready/valid port until stopped or exhausted.
module md5_block_builder
    import md5_pkg::*;
#(
    parameter int MAX_KEY_BYTES = 16,
    parameter int NONCE_DIGITS  = 10,
    parameter int START_NONCE   = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    output logic                   key_ready,
    input  logic                   key_valid,
    input  logic [7:0]             key_data,
    input  logic                   key_last,
    input  logic                   stop,
    input  logic                   md5_block_ready,
    output logic                   md5_block_valid,
    output logic [BLOCK_WIDTH-1:0] md5_block_data,
    output logic [31:0]            nonce,
    output logic                   done,
    output logic                   error
);

    localparam int KLW = $clog2(MAX_KEY_BYTES + 1);
    localparam int KAW = (MAX_KEY_BYTES > 1) ? $clog2(MAX_KEY_BYTES) : 1;
    localparam int NDW = $clog2(NONCE_DIGITS + 1);
    localparam int IW  = $clog2(BLOCK_BYTES);
    localparam int MW  = 8;

    state_t         state_q, state_d;
    logic [IW-1:0]  fill_idx_q, fill_idx_d;
    logic [KLW-1:0] key_len_q, key_len_d;
    md5_block_t     block_q, block_d;
    logic           valid_q, valid_d;
    logic           key_ready_q, key_ready_d;
    logic           done_q, done_d;
    logic           error_q, error_d;
    logic [31:0]    nonce_q, nonce_d;
    logic [31:0]    bin_q, bin_d;

    byte_t key_mem [MAX_KEY_BYTES];
    logic  key_we;
    byte_t key_byte;

    logic [4*NONCE_DIGITS-1:0] bcd_digits;
    logic [NDW-1:0]            num_digits;
    logic                      bcd_inc;
    logic                      bcd_grow;
    logic                      bcd_overflow;

    logic [MW-1:0]   idx, msg_len, digit_pos, digit_sel, grown_len, loaded_len;
    logic [MW+2:0]   msg_bits;
    logic [3:0]      digit;
    byte_t           fill_byte;
    logic            exhausted;

    bcd_counter #(
        .DIGITS      (NONCE_DIGITS),
        .START_VALUE (START_NONCE)
    ) u_bcd (
        .clk        (clk),
        .reset_n    (reset_n),
        .inc        (bcd_inc),
        .digits     (bcd_digits),
        .num_digits (num_digits),
        .grow       (bcd_grow),
        .overflow   (bcd_overflow)
    );

    always_ff @(posedge clk) begin
        if (key_we) begin
            key_mem[key_len_q[KAW-1:0]] <= key_data;
        end
    end

    assign key_byte = key_mem[fill_idx_q[KAW-1:0]];

    // Byte generator for the current fill index.
    always_comb begin
        idx        = MW'(fill_idx_q);
        msg_len    = MW'(key_len_q) + MW'(num_digits);
        digit_pos  = idx - MW'(key_len_q);
        digit_sel  = MW'(num_digits) - MW'(1) - digit_pos;
        msg_bits   = {msg_len, 3'b000};
        grown_len  = msg_len + MW'(bcd_grow);
        loaded_len = msg_len + MW'(1);
        exhausted  = bcd_overflow || (grown_len > MW'(MAX_MSG_BYTES));
        digit      = 4'd0;
        for (int d = 0; d < NONCE_DIGITS; d++) begin
            if (MW'(d) == digit_sel) begin
                digit = bcd_digits[4*d +: 4];
            end
        end
        if (idx < MW'(key_len_q)) begin
            fill_byte = key_byte;
        end else if (idx < msg_len) begin
            fill_byte = ASCII_ZERO | {4'h0, digit};
        end else if (idx == msg_len) begin
            fill_byte = PAD_BYTE;
        end else if (idx == MW'(LEN_OFFSET)) begin
            fill_byte = msg_bits[7:0];
        end else if (idx == MW'(LEN_OFFSET + 1)) begin
            fill_byte = {5'b0, msg_bits[MW+2:8]};
        end else begin
            fill_byte = 8'h00;
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_idx_d  = fill_idx_q;
        key_len_d   = key_len_q;
        block_d     = block_q;
        valid_d     = valid_q;
        key_ready_d = key_ready_q;
        done_d      = done_q;
        error_d     = error_q;
        nonce_d     = nonce_q;
        bin_d       = bin_q;
        key_we      = 1'b0;
        bcd_inc     = 1'b0;

        unique case (state_q)
            LOAD: begin
                if (key_valid && key_ready_q) begin
                    if (key_len_q == KLW'(MAX_KEY_BYTES)) begin
                        state_d     = DONE;
                        key_ready_d = 1'b0;
                        done_d      = 1'b1;
                        error_d     = 1'b1;
                    end else begin
                        key_we    = 1'b1;
                        key_len_d = key_len_q + KLW'(1);
                        if (key_last) begin
                            key_ready_d = 1'b0;
                            fill_idx_d  = '0;
                            if (loaded_len > MW'(MAX_MSG_BYTES)) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                                error_d = 1'b1;
                            end else begin
                                state_d = FILL;
                            end
                        end
                    end
                end
            end
            FILL: begin
                if (stop) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    for (int b = 0; b < BLOCK_BYTES; b++) begin
                        if (IW'(b) == fill_idx_q) begin
                            block_d[BLOCK_WIDTH-1-8*b -: 8] = fill_byte;
                        end
                    end
                    fill_idx_d = fill_idx_q + IW'(1);
                    if (fill_idx_q == IW'(BLOCK_BYTES - 1)) begin
                        state_d = OFFER;
                        valid_d = 1'b1;
                    end
                end
            end
            OFFER: begin
                if (md5_block_ready) begin
                    nonce_d    = bin_q;
                    bin_d      = bin_q + 32'd1;
                    bcd_inc    = 1'b1;
                    valid_d    = 1'b0;
                    fill_idx_d = '0;
                    if (stop) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (exhausted) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end else if (stop) begin
                    // Abort: withdraw the pending block without a transfer.
                    state_d = DONE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
            end
            default: begin
                state_d = DONE;
                valid_d = 1'b0;
                done_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= LOAD;
            fill_idx_q  <= '0;
            key_len_q   <= '0;
            block_q     <= '0;
            valid_q     <= 1'b0;
            key_ready_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            nonce_q     <= '0;
            bin_q       <= 32'(START_NONCE);
        end else begin
            state_q     <= state_d;
            fill_idx_q  <= fill_idx_d;
            key_len_q   <= key_len_d;
            block_q     <= block_d;
            valid_q     <= valid_d;
            key_ready_q <= key_ready_d;
            done_q      <= done_d;
            error_q     <= error_d;
            nonce_q     <= nonce_d;
            bin_q       <= bin_d;
        end
    end

    assign key_ready       = key_ready_q;
    assign md5_block_valid = valid_q;
    assign md5_block_data  = block_q;
    assign nonce           = nonce_q;
    assign done            = done_q;
    assign error           = error_q;

endmodule

// File: tb/tb_md5_block_builder.sv
// Directed bench for md5_block_builder: three instances cover a long nonce, nonce
// digit roll-over with backpressure/stop/reset, and nonce digit exhaustion.
module tb_md5_block_builder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n  [3];
    logic         kvalid [3];
    logic [7:0]   kdata  [3];
    logic         klast  [3];
    logic         stop   [3];
    logic         rdy    [3];
    logic         kready [3];
    logic         bvalid [3];
    logic [511:0] bdata  [3];
    logic [31:0]  nonce  [3];
    logic         done   [3];
    logic         error  [3];

    int total = 0;
    int bad   = 0;

    localparam logic [511:0] E_A  = {"abcdef609043", 8'h80, 344'h0, 8'h60, 56'h0};
    localparam logic [511:0] E_B1 = {"abcdef9", 8'h80, 384'h0, 8'h38, 56'h0};
    localparam logic [511:0] E_B2 = {"abcdef10", 8'h80, 376'h0, 8'h40, 56'h0};
    localparam logic [511:0] E_C  = {"a9", 8'h80, 424'h0, 8'h10, 56'h0};
    localparam logic [511:0] E_D  = {"ab9", 8'h80, 416'h0, 8'h18, 56'h0};

    md5_block_builder #(.MAX_KEY_BYTES(16), .NONCE_DIGITS(10), .START_NONCE(609043)) u_a (
        .clk(clk), .reset_n(rst_n[0]), .key_ready(kready[0]), .key_valid(kvalid[0]),
        .key_data(kdata[0]), .key_last(klast[0]), .stop(stop[0]), .md5_block_ready(rdy[0]),
        .md5_block_valid(bvalid[0]), .md5_block_data(bdata[0]), .nonce(nonce[0]),
        .done(done[0]), .error(error[0]));

    md5_block_builder #(.MAX_KEY_BYTES(16), .NONCE_DIGITS(10), .START_NONCE(9)) u_b (
        .clk(clk), .reset_n(rst_n[1]), .key_ready(kready[1]), .key_valid(kvalid[1]),
        .key_data(kdata[1]), .key_last(klast[1]), .stop(stop[1]), .md5_block_ready(rdy[1]),
        .md5_block_valid(bvalid[1]), .md5_block_data(bdata[1]), .nonce(nonce[1]),
        .done(done[1]), .error(error[1]));

    md5_block_builder #(.MAX_KEY_BYTES(16), .NONCE_DIGITS(1), .START_NONCE(9)) u_c (
        .clk(clk), .reset_n(rst_n[2]), .key_ready(kready[2]), .key_valid(kvalid[2]),
        .key_data(kdata[2]), .key_last(klast[2]), .stop(stop[2]), .md5_block_ready(rdy[2]),
        .md5_block_valid(bvalid[2]), .md5_block_data(bdata[2]), .nonce(nonce[2]),
        .done(done[2]), .error(error[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input int sel, input string s);
        for (int k = 0; k < s.len(); k++) begin
            kvalid[sel] = 1'b1;
            kdata[sel]  = s[k];
            klast[sel]  = (k == s.len() - 1);
            tick();
        end
        kvalid[sel] = 1'b0;
        klast[sel]  = 1'b0;
    endtask

    task automatic wait_valid(input int sel, output int n);
        n = 0;
        while (bvalid[sel] !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic accept(input int sel);
        rdy[sel] = 1'b1;
        tick();
        rdy[sel] = 1'b0;
        $display("block accepted: inst=%0d nonce=%0d done=%0b error=%0b",
                 sel, nonce[sel], done[sel], error[sel]);
    endtask

    task automatic pulse_reset(input int sel);
        rst_n[sel] = 1'b0;
        tick();
        rst_n[sel] = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            rst_n[s] = 1'b0; kvalid[s] = 1'b0; kdata[s] = 8'h00;
            klast[s] = 1'b0; stop[s] = 1'b0; rdy[s] = 1'b0;
        end
        repeat (3) tick();
        for (int s = 0; s < 3; s++) begin
            total++;
            if ({kready[s], bvalid[s], done[s], error[s]} !== 4'b1000) begin
                bad++;
                $display("FAIL reset_flags inst=%0d: got %b want 1000", s,
                         {kready[s], bvalid[s], done[s], error[s]});
            end
            total++;
            if (bdata[s] !== 512'h0 || nonce[s] !== 32'h0) begin
                bad++;
                $display("FAIL reset_data inst=%0d: data=%h nonce=%h want zero", s, bdata[s], nonce[s]);
            end
        end
        for (int s = 0; s < 3; s++) rst_n[s] = 1'b1;
        tick();
    endtask

    task automatic test_first_block();
        int n;
        load_key(0, "abcdef");
        wait_valid(0, n);
        total++;
        if (n !== 64) begin
            bad++;
            $display("FAIL first_latency: got %0d want 64", n);
        end
        total++;
        if (bdata[0] !== E_A) begin
            bad++;
            $display("FAIL first_block: got %h want %h", bdata[0], E_A);
        end
        accept(0);
        total++;
        if (nonce[0] !== 32'd609043 || bvalid[0] !== 1'b0) begin
            bad++;
            $display("FAIL first_nonce: got %0d valid=%b want 609043 valid=0", nonce[0], bvalid[0]);
        end
    endtask

    task automatic test_stop_fill();
        int seen;
        seen = 0;
        repeat (5) tick();
        stop[0] = 1'b1;
        tick();
        stop[0] = 1'b0;
        total++;
        if ({done[0], error[0], bvalid[0]} !== 3'b100) begin
            bad++;
            $display("FAIL stop_fill: got done/err/valid=%b want 100", {done[0], error[0], bvalid[0]});
        end
        repeat (80) begin
            tick();
            if (bvalid[0] !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL stop_fill_quiet: valid cycles got %0d want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int bp_bad;
        logic [511:0] held;
        load_key(1, "abcdef");
        wait_valid(1, n);
        total++;
        if (n !== 64 || bdata[1] !== E_B1) begin
            bad++;
            $display("FAIL b1_block: lat=%0d data=%h want 64 %h", n, bdata[1], E_B1);
        end
        held   = bdata[1];
        bp_bad = 0;
        repeat (10) begin
            tick();
            if (bvalid[1] !== 1'b1 || bdata[1] !== held || nonce[1] !== 32'd0) bp_bad++;
        end
        total++;
        if (bp_bad !== 0) begin
            bad++;
            $display("FAIL backpressure: unstable cycles got %0d want 0", bp_bad);
        end
        accept(1);
        total++;
        if (nonce[1] !== 32'd9 || bvalid[1] !== 1'b0) begin
            bad++;
            $display("FAIL b1_nonce: got %0d valid=%b want 9 valid=0", nonce[1], bvalid[1]);
        end
        wait_valid(1, n);
        total++;
        if (n !== 64 || bdata[1] !== E_B2) begin
            bad++;
            $display("FAIL b2_block: lat=%0d data=%h want 64 %h", n, bdata[1], E_B2);
        end
    endtask

    task automatic test_stop_handshake();
        int seen;
        seen    = 0;
        stop[1] = 1'b1;
        accept(1);
        stop[1] = 1'b0;
        total++;
        if (nonce[1] !== 32'd10 || {done[1], error[1], bvalid[1]} !== 3'b100) begin
            bad++;
            $display("FAIL stop_hs: nonce=%0d flags=%b want 10 100", nonce[1], {done[1], error[1], bvalid[1]});
        end
        repeat (70) begin
            tick();
            if (bvalid[1] !== 1'b0 || kready[1] !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL stop_hs_quiet: active cycles got %0d want 0", seen);
        end
    endtask

    task automatic test_digit_overflow();
        int n;
        int seen;
        seen = 0;
        load_key(2, "a");
        wait_valid(2, n);
        total++;
        if (n !== 64 || bdata[2] !== E_C) begin
            bad++;
            $display("FAIL ovf_block: lat=%0d data=%h want 64 %h", n, bdata[2], E_C);
        end
        accept(2);
        total++;
        if (nonce[2] !== 32'd9 || {done[2], error[2]} !== 2'b11) begin
            bad++;
            $display("FAIL ovf_end: nonce=%0d done/err=%b want 9 11", nonce[2], {done[2], error[2]});
        end
        repeat (70) begin
            tick();
            if (bvalid[2] !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL ovf_quiet: valid cycles got %0d want 0", seen);
        end
    endtask

    task automatic test_reset_midfill();
        int n;
        pulse_reset(1);
        load_key(1, "ab");
        wait_valid(1, n);
        accept(1);
        repeat (30) tick();
        rst_n[1] = 1'b0;
        #1;
        total++;
        if ({kready[1], bvalid[1], done[1], error[1]} !== 4'b1000 || bdata[1] !== 512'h0 || nonce[1] !== 32'd0) begin
            bad++;
            $display("FAIL midfill_reset: flags=%b nonce=%0d data=%h want 1000 0 0",
                     {kready[1], bvalid[1], done[1], error[1]}, nonce[1], bdata[1]);
        end
        tick();
        rst_n[1] = 1'b1;
        load_key(1, "ab");
        wait_valid(1, n);
        total++;
        if (n !== 64 || bdata[1] !== E_D) begin
            bad++;
            $display("FAIL reload_block: lat=%0d data=%h want 64 %h", n, bdata[1], E_D);
        end
        rst_n[1] = 1'b0;
        #1;
        total++;
        if (bvalid[1] !== 1'b0) begin
            bad++;
            $display("FAIL offer_async_reset: valid got %b want 0", bvalid[1]);
        end
        tick();
        rst_n[1] = 1'b1;
        tick();
    endtask

    task automatic test_long_key();
        int seen;
        seen = 0;
        load_key(1, "abcdefghijklmnopq");
        total++;
        if ({kready[1], done[1], error[1]} !== 3'b011) begin
            bad++;
            $display("FAIL long_key: ready/done/err got %b want 011", {kready[1], done[1], error[1]});
        end
        repeat (70) begin
            tick();
            if (bvalid[1] !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL long_key_quiet: valid cycles got %0d want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_first_block();
        test_stop_fill();
        test_back_to_back();
        test_stop_handshake();
        test_digit_overflow();
        test_reset_midfill();
        test_long_key();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
